writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage of core_lapido. Accepts retiring results from the MEM stage and merges
//  LCL/LCH partial constants. Waits on load data from data memory, with a timeout.
//  Drives the write side (en/rd/data) of the GPR register file.
//  Supplies JAL link writes, which the register file does not generate itself.
// PARAMETERS
//  GPR_WIDTH    32   data width of one GPR
//  REG_ADDR_W   5    width of register index
//  REG_COUNT    16   implemented GPRs; indices >= REG_COUNT are never written
//  MEM_TIMEOUT  255  max cycles waiting for mem_rvalid before abort (>=1)
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             reset, asynchronous, active-high
//  wb_valid     in   1             MEM stage presents a retiring instruction
//  wb_ready     out  1             unit can accept (handshake = wb_valid & wb_ready)
//  wb_src       in   3             result source, `WB_SRC_* code
//  wb_rd        in   REG_ADDR_W    destination register
//  wb_alu       in   GPR_WIDTH     ALU result
//  wb_link      in   GPR_WIDTH     PC+1 for JAL
//  wb_imm16     in   16            constant for LCL/LCH
//  wb_rd_old    in   GPR_WIDTH     current rd contents (LCL/LCH merge)
//  mem_rvalid   in   1             load data valid
//  mem_rdata    in   GPR_WIDTH     load data
//  rf_en        out  1             register-file write enable
//  rf_rd        out  REG_ADDR_W    register-file write index
//  rf_data      out  GPR_WIDTH     register-file write data
//  wb_err       out  1             1-cycle pulse: load timeout or illegal rd/src
//  fwd_valid    out  1             bypass valid (optional feature)
//  fwd_rd       out  REG_ADDR_W    bypass index
//  fwd_data     out  GPR_WIDTH     bypass data
// BEHAVIOUR
//  Reset: state IDLE; wb_ready=1; rf_en=0, rf_rd=0, rf_data=0; wb_err=0; fwd_*=0; timeout cnt=0.
//  FSM IDLE/WAIT_MEM. wb_ready = (state==IDLE).
//  Data selection for a non-load accepted in IDLE:
//   ALU->wb_alu; LINK->wb_link;
//   LCL->{wb_rd_old[31:16],imm16}; LCH->{imm16,wb_rd_old[15:0]}; NONE->no write.
//  Non-load accepted in IDLE: rf_en/rf_rd/rf_data registered, asserted the next cycle (latency 1).
//   State stays IDLE, so throughput is 1/cycle.
//  LOAD accepted: latch rd, go WAIT_MEM, cnt=0. No rf write that cycle.
//   mem_rvalid is ignored outside WAIT_MEM (including the accept cycle).
//  WAIT_MEM: cnt increments each cycle.
//   mem_rvalid=1: rf write of mem_rdata next cycle; back to IDLE.
//   cnt==MEM_TIMEOUT-1 with no rvalid: no write; wb_err pulse next cycle; back to IDLE.
//   rvalid and timeout in the same cycle: data wins, no error.
//  rf_en is a 1-cycle pulse per write; rf_rd/rf_data hold their last value when rf_en=0.
//  rd>=REG_COUNT or undefined wb_src: write suppressed, wb_err pulse next cycle. A load is not entered.
//  rst mid-WAIT_MEM: abort immediately. No write, no error pulse.
// CONFIGURATION
//  LAPIDO_WB_FWD_EN defined: fwd_valid/rd/data mirror the registered rf_en/rf_rd/rf_data.
//   Decode bypasses same-cycle writes with them (the register file has no write-through).
//  Not defined: fwd_valid, fwd_rd and fwd_data are tied to 0.
// STRUCTURE
//  lapido_defs.v: `WB_SRC_NONE=0, ALU=1, MEM=2, LINK=3, LCL=4, LCH=5; `GPR_WIDTH; `REGISTER_FILE_SIZE.
//  Sub-module wb_data_mux: combinational wb_src/imm16/rd_old -> data + legal flag.
//  The FSM, counter and output registers live in the top.
// TESTING
//  ALU r3=0x12345678 -> next cycle rf_en=1, rf_rd=3, rf_data=0x12345678; wb_ready stays 1.
//  LCL r5 imm 0xBEEF, old 0xAAAA0000 -> rf_data=0xAAAABEEF.
//   LCH imm 0x1234, old 0x0000BEEF -> 0x1234BEEF.
//  LOAD r7; rvalid after 4 cycles with 0xCAFE0001 -> wb_ready=0 throughout.
//   Single write r7=0xCAFE0001; ready=1 after.
//  LOAD, no rvalid, MEM_TIMEOUT=8 -> no rf_en; wb_err pulse once; IDLE.
//   rvalid on cycle 8 -> write, no err.
//  rd=20 ALU -> no rf_en, wb_err=1 one cycle.
//   rst asserted mid WAIT_MEM -> all outputs 0, wb_ready=1.
//  Back-to-back ALU r1,r2,r3 with LAPIDO_WB_FWD_EN -> 3 consecutive rf_en cycles; fwd matches.
//   Without the macro, fwd_* stay 0.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the core_lapido writeback stage: result-source
// codes, FSM state encoding and legality helpers.
package writeback_unit_pkg;

    // Result source codes presented by the MEM stage on wb_src.
    typedef enum logic [2:0] {
        WB_SRC_NONE = 3'd0,
        WB_SRC_ALU  = 3'd1,
        WB_SRC_MEM  = 3'd2,
        WB_SRC_LINK = 3'd3,
        WB_SRC_LCL  = 3'd4,
        WB_SRC_LCH  = 3'd5
    } wb_src_e;

    // Writeback FSM: either free to retire, or parked on an outstanding load.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    localparam int WB_SRC_W = 3;

    // True for every source code the stage knows how to retire.
    function automatic logic src_is_defined(input logic [WB_SRC_W-1:0] src);
        logic ok_v;
        case (src)
            WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM,
            WB_SRC_LINK, WB_SRC_LCL, WB_SRC_LCH: ok_v = 1'b1;
            default:                             ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

endpackage

// File: rtl/writeback_unit_data_mux.sv
// wb_data_mux: combinational result selection for the writeback stage.
// Picks the write data from the retiring instruction's source, merges the
// LCL/LCH 16-bit constants into the old rd value, and flags whether the
// instruction writes, is a load, and is legal (defined source, and an
// implemented destination when a destination is actually used).
module wb_data_mux
    import writeback_unit_pkg::*;
#(
    parameter int GPR_WIDTH  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int REG_COUNT  = 16
) (
    input  logic [2:0]            wb_src,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [GPR_WIDTH-1:0]  wb_alu,
    input  logic [GPR_WIDTH-1:0]  wb_link,
    input  logic [15:0]           wb_imm16,
    input  logic [GPR_WIDTH-1:0]  wb_rd_old,
    output logic [GPR_WIDTH-1:0]  data,
    output logic                  writes,
    output logic                  is_load,
    output logic                  legal
);

    localparam logic [REG_ADDR_W:0] RD_LIMIT = (REG_ADDR_W + 1)'(REG_COUNT);

    logic rd_ok_s;
    logic src_ok_s;

    // Destination index is within the implemented register file.
    assign rd_ok_s  = ({1'b0, wb_rd} < RD_LIMIT);
    assign src_ok_s = src_is_defined(wb_src);

    // Select write data and classify the instruction by its source.
    always_comb begin
        data    = {GPR_WIDTH{1'b0}};
        writes  = 1'b0;
        is_load = 1'b0;
        case (wb_src)
            WB_SRC_NONE: begin
                writes = 1'b0;
            end
            WB_SRC_ALU: begin
                data   = wb_alu;
                writes = 1'b1;
            end
            WB_SRC_MEM: begin
                is_load = 1'b1;
            end
            WB_SRC_LINK: begin
                data   = wb_link;
                writes = 1'b1;
            end
            WB_SRC_LCL: begin
                data        = wb_rd_old;
                data[15:0]  = wb_imm16;
                writes      = 1'b1;
            end
            WB_SRC_LCH: begin
                data        = wb_rd_old;
                data[31:16] = wb_imm16;
                writes      = 1'b1;
            end
            default: begin
                data    = {GPR_WIDTH{1'b0}};
                writes  = 1'b0;
                is_load = 1'b0;
            end
        endcase
    end

    // A NONE instruction has no destination, so its rd field is not checked.
    assign legal = src_ok_s & (rd_ok_s | ~(writes | is_load));

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage of core_lapido.
// Retires MEM-stage results into the GPR register file write port, waits
// (with a timeout) for load data, and pulses wb_err on load timeout or on
// an illegal destination/source. Register-file writes are registered, so
// they appear one cycle after the triggering event.
// Optional feature macro: LAPIDO_WB_FWD_EN -- when defined, fwd_valid/
// fwd_rd/fwd_data mirror the registered write port for decode bypass;
// otherwise they are tied to zero.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int GPR_WIDTH   = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int REG_COUNT   = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [2:0]            wb_src,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [GPR_WIDTH-1:0]  wb_alu,
    input  logic [GPR_WIDTH-1:0]  wb_link,
    input  logic [15:0]           wb_imm16,
    input  logic [GPR_WIDTH-1:0]  wb_rd_old,
    input  logic                  mem_rvalid,
    input  logic [GPR_WIDTH-1:0]  mem_rdata,
    output logic                  rf_en,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [GPR_WIDTH-1:0]  rf_data,
    output logic                  wb_err,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [GPR_WIDTH-1:0]  fwd_data
);

    // Counter only needs to reach MEM_TIMEOUT-1 (the last waiting cycle).
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    wb_state_e             state_r;
    wb_state_e             next_state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [REG_ADDR_W-1:0] load_rd_r;
    logic [REG_ADDR_W-1:0] load_rd_next_s;

    logic                  rf_en_next_s;
    logic [REG_ADDR_W-1:0] rf_rd_next_s;
    logic [GPR_WIDTH-1:0]  rf_data_next_s;
    logic                  wb_err_next_s;

    logic                  accept_s;
    logic [GPR_WIDTH-1:0]  mux_data_s;
    logic                  mux_writes_s;
    logic                  mux_is_load_s;
    logic                  mux_legal_s;

    wb_data_mux #(
        .GPR_WIDTH  (GPR_WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .REG_COUNT  (REG_COUNT)
    ) u_data_mux (
        .wb_src    (wb_src),
        .wb_rd     (wb_rd),
        .wb_alu    (wb_alu),
        .wb_link   (wb_link),
        .wb_imm16  (wb_imm16),
        .wb_rd_old (wb_rd_old),
        .data      (mux_data_s),
        .writes    (mux_writes_s),
        .is_load   (mux_is_load_s),
        .legal     (mux_legal_s)
    );

    assign wb_ready = (state_r == ST_IDLE);
    assign accept_s = wb_valid & wb_ready;

    // Next-state, timeout counter and next register-file write computation.
    always_comb begin
        next_state_s   = state_r;
        cnt_next_s     = cnt_r;
        load_rd_next_s = load_rd_r;
        rf_en_next_s   = 1'b0;
        rf_rd_next_s   = rf_rd;
        rf_data_next_s = rf_data;
        wb_err_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!mux_legal_s) begin
                        wb_err_next_s = 1'b1;
                    end else if (mux_is_load_s) begin
                        next_state_s   = ST_WAIT_MEM;
                        cnt_next_s     = CNT_ZERO;
                        load_rd_next_s = wb_rd;
                    end else if (mux_writes_s) begin
                        rf_en_next_s   = 1'b1;
                        rf_rd_next_s   = wb_rd;
                        rf_data_next_s = mux_data_s;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // Data arriving on the last waiting cycle still wins.
                if (mem_rvalid) begin
                    rf_en_next_s   = 1'b1;
                    rf_rd_next_s   = load_rd_r;
                    rf_data_next_s = mem_rdata;
                    next_state_s   = ST_IDLE;
                    cnt_next_s     = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    wb_err_next_s = 1'b1;
                    next_state_s  = ST_IDLE;
                    cnt_next_s    = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered write-port/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            load_rd_r <= {REG_ADDR_W{1'b0}};
            rf_en     <= 1'b0;
            rf_rd     <= {REG_ADDR_W{1'b0}};
            rf_data   <= {GPR_WIDTH{1'b0}};
            wb_err    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            load_rd_r <= load_rd_next_s;
            rf_en     <= rf_en_next_s;
            rf_rd     <= rf_rd_next_s;
            rf_data   <= rf_data_next_s;
            wb_err    <= wb_err_next_s;
        end
    end

`ifdef LAPIDO_WB_FWD_EN
    // The register file has no write-through; decode bypasses from these.
    assign fwd_valid = rf_en;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = {REG_ADDR_W{1'b0}};
    assign fwd_data  = {GPR_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_writeback_unit;

    localparam int GW  = 32;
    localparam int AW  = 5;
    localparam int RC  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_valid = 1'b0;
    logic          wb_ready;
    logic [2:0]    wb_src = 3'd0;
    logic [AW-1:0] wb_rd = 5'd0;
    logic [GW-1:0] wb_alu = 32'h0;
    logic [GW-1:0] wb_link = 32'h0;
    logic [15:0]   wb_imm16 = 16'h0;
    logic [GW-1:0] wb_rd_old = 32'h0;
    logic          mem_rvalid = 1'b0;
    logic [GW-1:0] mem_rdata = 32'h0;
    logic          rf_en;
    logic [AW-1:0] rf_rd;
    logic [GW-1:0] rf_data;
    logic          wb_err;
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [GW-1:0] fwd_data;

    writeback_unit #(
        .GPR_WIDTH(GW), .REG_ADDR_W(AW), .REG_COUNT(RC), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_src(wb_src), .wb_rd(wb_rd), .wb_alu(wb_alu), .wb_link(wb_link),
        .wb_imm16(wb_imm16), .wb_rd_old(wb_rd_old), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
        .wb_err(wb_err), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int en_seen = 0;
    int err_seen = 0;
    int ready_low = 0;

    // Behavioural model: "busy" while a load is outstanding, counting cycles waited.
    bit          m_busy = 1'b0;
    int          m_waited = 0;
    int          m_rd = 0;
    bit          x_en = 1'b0;
    bit          x_err = 1'b0;
    int          x_rd = 0;
    logic [31:0] x_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_waited = 0; m_rd = 0;
        x_en = 1'b0; x_err = 1'b0; x_rd = 0; x_data = 32'h0;
    endtask

    // Apply the stage's rules to the inputs present before the next edge.
    task automatic model_step();
        int src;
        int rd;
        bit legal;
        src = int'(wb_src);
        rd  = int'(wb_rd);
        x_en = 1'b0;
        x_err = 1'b0;
        if (!m_busy) begin
            if (wb_valid) begin
                legal = (src <= 5) && (src == 0 || rd < RC);
                if (!legal) x_err = 1'b1;
                else if (src == 2) begin
                    m_busy = 1'b1; m_waited = 0; m_rd = rd;
                end else if (src != 0) begin
                    x_en = 1'b1;
                    x_rd = rd;
                    case (src)
                        1: x_data = wb_alu;
                        3: x_data = wb_link;
                        4: x_data = (wb_rd_old & 32'hFFFF0000) | {16'h0, wb_imm16};
                        default: x_data = ({16'h0, wb_imm16} << 16) | (wb_rd_old & 32'h0000FFFF);
                    endcase
                end
            end
        end else begin
            m_waited++;
            if (mem_rvalid) begin
                x_en = 1'b1; x_rd = m_rd; x_data = mem_rdata; m_busy = 1'b0;
            end else if (m_waited == TMO) begin
                x_err = 1'b1; m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("rf_en", {31'h0, rf_en}, {31'h0, x_en});
        chk("rf_rd", {27'h0, rf_rd}, 32'(x_rd));
        chk("rf_data", rf_data, x_data);
        chk("wb_err", {31'h0, wb_err}, {31'h0, x_err});
        chk("wb_ready", {31'h0, wb_ready}, {31'h0, !m_busy});
`ifdef LAPIDO_WB_FWD_EN
        chk("fwd_valid", {31'h0, fwd_valid}, {31'h0, x_en});
        chk("fwd_rd", {27'h0, fwd_rd}, 32'(x_rd));
        chk("fwd_data", fwd_data, x_data);
`else
        chk("fwd_valid", {31'h0, fwd_valid}, 32'h0);
        chk("fwd_rd", {27'h0, fwd_rd}, 32'h0);
        chk("fwd_data", fwd_data, 32'h0);
`endif
        if (rf_en) en_seen++;
        if (wb_err) err_seen++;
        if (!wb_ready) ready_low++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input int src, input int rd, input logic [31:0] alu,
                         input logic [15:0] imm, input logic [31:0] old);
        wb_valid = v; wb_src = 3'(src); wb_rd = 5'(rd); wb_alu = alu;
        wb_link = alu + 32'd1; wb_imm16 = imm; wb_rd_old = old;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_en", {31'h0, rf_en}, 32'h0);
        chk("reset_rf_data", rf_data, 32'h0);
        chk("reset_ready", {31'h0, wb_ready}, 32'h1);
        chk("reset_err", {31'h0, wb_err}, 32'h0);
        rst = 1'b0;

        // ALU r3
        drive(1'b1, 1, 3, 32'h12345678, 16'h0, 32'h0);
        step();
        chk("alu_data", rf_data, 32'h12345678);
        chk("alu_rd", {27'h0, rf_rd}, 32'd3);
        // LCL r5, then LCH r5 back to back
        drive(1'b1, 4, 5, 32'h0, 16'hBEEF, 32'hAAAA0000);
        step();
        chk("lcl_data", rf_data, 32'hAAAABEEF);
        drive(1'b1, 5, 5, 32'h0, 16'h1234, 32'h0000BEEF);
        step();
        chk("lch_data", rf_data, 32'h1234BEEF);
        // JAL link write
        drive(1'b1, 3, 15, 32'h00000040, 16'h0, 32'h0);
        step();
        chk("link_data", rf_data, 32'h00000041);

        // LOAD r7 with rvalid asserted in the accept cycle (ignored), data 4 cycles later
        en_seen = 0; ready_low = 0;
        drive(1'b1, 2, 7, 32'h0, 16'h0, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD0000;
        step();
        wb_valid = 1'b0; mem_rvalid = 1'b0;
        repeat (3) step();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
        step();
        mem_rvalid = 1'b0;
        chk("load_data", rf_data, 32'hCAFE0001);
        chk("load_single_write", 32'(en_seen), 32'd1);
        chk("load_ready_low", 32'(ready_low), 32'd4);
        step();

        // LOAD timeout: no write, one error pulse
        en_seen = 0; err_seen = 0;
        drive(1'b1, 2, 9, 32'h0, 16'h0, 32'h0);
        step();
        wb_valid = 1'b0;
        repeat (TMO + 2) step();
        chk("timeout_no_write", 32'(en_seen), 32'd0);
        chk("timeout_err_once", 32'(err_seen), 32'd1);

        // rvalid on the last waiting cycle: data wins
        en_seen = 0; err_seen = 0;
        drive(1'b1, 2, 10, 32'h0, 16'h0, 32'h0);
        step();
        wb_valid = 1'b0;
        repeat (TMO - 1) step();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_rvalid = 1'b0;
        repeat (2) step();
        chk("edge_write_once", 32'(en_seen), 32'd1);
        chk("edge_no_err", 32'(err_seen), 32'd0);

        // Illegal rd and undefined source
        drive(1'b1, 1, 20, 32'h55555555, 16'h0, 32'h0);
        step();
        chk("bad_rd_err", {31'h0, wb_err}, 32'h1);
        drive(1'b1, 7, 2, 32'h0, 16'h0, 32'h0);
        step();
        drive(1'b1, 2, 17, 32'h0, 16'h0, 32'h0);
        step();
        chk("bad_load_not_entered", {31'h0, wb_ready}, 32'h1);

        // Reset in the middle of WAIT_MEM
        drive(1'b1, 2, 4, 32'h0, 16'h0, 32'h0);
        step();
        wb_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_rf_en", {31'h0, rf_en}, 32'h0);
        chk("midrst_rf_rd", {27'h0, rf_rd}, 32'h0);
        chk("midrst_rf_data", rf_data, 32'h0);
        chk("midrst_err", {31'h0, wb_err}, 32'h0);
        chk("midrst_ready", {31'h0, wb_ready}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Back-to-back ALU r1, r2, r3
        en_seen = 0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1, i, 32'(i * 32'h1111), 16'h0, 32'h0);
            step();
        end
        wb_valid = 1'b0;
        chk("b2b_writes", 32'(en_seen), 32'd3);
        step();

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            int src;
            int rd;
            src = $urandom_range(0, 7);
            rd  = $urandom_range(0, 31);
            if (src == 0) rd = rd % RC;
            drive(($urandom_range(0, 3) != 0), src, rd, $urandom,
                  16'($urandom), $urandom);
            mem_rvalid = ($urandom_range(0, 4) == 0);
            mem_rdata  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
